// File: rtl/sram_bridge_pkg.sv
// Shared encodings for the bus-to-SRAM bridge: access sizes, FSM states and
// the request legality check.
package sram_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_ERR
  } state_e;

  // A request is legal when its size fits the SRAM word and its address is size-aligned.
  function automatic logic size_ok(input logic [1:0] sz, input logic [1:0] lo, input int data_w);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return !lo[0];
      SZ_WORD: return (data_w == 32) && (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sram_lane_mux.sv
// Byte-lane steering between the right-justified bus side and the SRAM word:
// read extract, write placement, read-modify-write merge and lane mask.
module sram_lane_mux #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                    size_i,
  input  logic [$clog2(DATA_W/8)-1:0]   off_i,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rd_ext_o,
  output logic [DATA_W-1:0]             wr_place_o,
  output logic [DATA_W-1:0]             merged_o,
  output logic [DATA_W/8-1:0]           lane_o
);
  localparam int NB = DATA_W / 8;

  int nbytes;

  always_comb begin
    nbytes     = 32'd1 << size_i;
    lane_o     = '0;
    rd_ext_o   = '0;
    wr_place_o = '0;
    merged_o   = rdata_i;
    for (int l = 0; l < NB; l++) begin
      if (l >= int'(off_i) && l < int'(off_i) + nbytes) begin
        lane_o[l]                          = 1'b1;
        rd_ext_o[(l - int'(off_i))*8 +: 8] = rdata_i[l*8 +: 8];
        wr_place_o[l*8 +: 8]               = wdata_i[(l - int'(off_i))*8 +: 8];
        merged_o[l*8 +: 8]                 = wdata_i[(l - int'(off_i))*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// Single-master bus bridge to an asynchronous SRAM with programmable strobe
// timing, sub-word access (byte enables or read-modify-write) and error response.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 22,
  parameter int RAM_AW    = 20,
  parameter int HAS_BE    = 0,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int READ_CYC  = 1
) (
  input  logic                  Hclock,
  input  logic                  Hreset,
  input  logic                  Hselect,
  input  logic                  ready,
  input  logic                  Hwrite,
  input  logic [1:0]            Hsize,
  input  logic [ADDR_W-1:0]     Haddress,
  input  logic [DATA_W-1:0]     Hwritedata,
  output logic [DATA_W-1:0]     Hreaddata,
  output logic                  Hready,
  output logic                  Hresponse,
  output logic                  RamEN,
  output logic                  RamOE,
  output logic                  RamWE,
  output logic [DATA_W/8-1:0]   RamBE,
  output logic [RAM_AW-1:0]     RamAddress,
  inout  wire  [DATA_W-1:0]     RamData
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = 8;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RAM_AW-1:0]   waddr_q;
  logic [LB-1:0]       off_q;
  logic [DATA_W-1:0]   rdata_q, wdata_q, rmw_q;
  logic [1:0]          size_q;
  logic                sub_q;
  logic                sub_w, accept, cap_rd, cap_rmw, drive;
  logic [DATA_W-1:0]   rd_ext, wr_place, merged;
  logic [NB-1:0]       lane;

  // Sub-word writes need a read-modify-write pass only when the chip has no byte enables.
  assign sub_w = (HAS_BE == 0) &&
                 ((Hsize == SZ_BYTE) || (Hsize == SZ_HALF && DATA_W == 32));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cap_rd  = 1'b0;
    cap_rmw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Hselect && ready) begin
          accept = 1'b1;
          if (!size_ok(Hsize, Haddress[1:0], DATA_W)) begin
            state_d = S_ERR;
          end else if (!Hwrite) begin
            state_d = S_RD;
            cnt_d   = CW'(READ_CYC - 1);
          end else if (sub_w) begin
            state_d = S_RMW_RD;
            cnt_d   = CW'(READ_CYC - 1);
          end else begin
            state_d = S_WR_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          cap_rd  = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_RMW_RD: begin
        if (cnt_q == '0) begin
          cap_rmw = 1'b1;
          state_d = S_WR_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WR_PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WR_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        waddr_q <= Haddress[LB+RAM_AW-1:LB];
        off_q   <= Haddress[LB-1:0];
      end
      if (cap_rd) rdata_q <= rd_ext;
    end
  end

  always_ff @(posedge Hclock) begin
    if (accept) begin
      size_q  <= Hsize;
      wdata_q <= Hwritedata;
      sub_q   <= sub_w;
    end
    if (cap_rmw) rmw_q <= merged;
  end

  sram_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
    .size_i     (size_q),
    .off_i      (off_q),
    .rdata_i    (RamData),
    .wdata_i    (wdata_q),
    .rd_ext_o   (rd_ext),
    .wr_place_o (wr_place),
    .merged_o   (merged),
    .lane_o     (lane)
  );

  assign drive      = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD);
  assign RamData    = drive ? (sub_q ? rmw_q : wr_place) : {DATA_W{1'bz}};
  assign RamAddress = waddr_q;
  assign Hreaddata  = rdata_q;
  assign Hready     = (state_q == S_IDLE) || (state_q == S_ERR);
  assign Hresponse  = (state_q == S_ERR);
  assign RamEN      = !((state_q == S_RD) || (state_q == S_RMW_RD) || (state_q == S_WR_PULSE));
  assign RamOE      = !((state_q == S_RD) || (state_q == S_RMW_RD));
  assign RamWE      = !(state_q == S_WR_PULSE);

  // With byte enables, only addressed lanes are written; without, every active cycle enables all lanes.
  always_comb begin
    RamBE = '1;
    if (HAS_BE != 0) begin
      if (state_q == S_RD) RamBE = '0;
      else if (state_q == S_WR_PULSE) RamBE = ~lane;
    end else if (state_q != S_IDLE && state_q != S_ERR) begin
      RamBE = '0;
    end
  end

endmodule
